// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  // Ceiling log2 that never returns less than 1, so a one-digit
  // converter still gets a legal one-bit counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One decimal accumulate step: sum = acc*10 + d, with the carry-out
// beyond BIN_W bits reported as ovf and non-decimal digits as bad_digit.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BIN_W = 17
) (
  input  logic [BIN_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] d,
  output logic [BIN_W-1:0]   sum,
  output logic               ovf,
  output logic               bad_digit
);

  // Four extra bits hold the worst case (2^BIN_W-1)*10+15 exactly.
  logic [BIN_W+3:0] acc_wide;
  logic [BIN_W+3:0] wide;

  assign acc_wide  = {4'b0000, acc};
  // acc*10 as (acc<<3)+(acc<<1) keeps this a pair of adders, no multiplier.
  assign wide      = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, d};
  assign sum       = wide[BIN_W-1:0];
  assign ovf       = |wide[BIN_W+3:BIN_W];
  assign bad_digit = (d > DIGIT_W'(MAX_DIGIT));

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// with valid/ready handshakes on both sides and sticky error flags.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int BIN_W      = 17
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              binary,
  output logic                          digit_err,
  output logic                          overflow
);

  localparam int CW = clog2_min1(NUM_DIGITS);
  localparam int SW = DIGIT_W * NUM_DIGITS;

  state_t               state_reg;
  state_t               state_next;
  logic [SW-1:0]        shift_reg;
  logic [CW-1:0]        count_reg;
  logic [BIN_W-1:0]     acc_reg;
  logic                 derr_reg;
  logic                 ovf_reg;

  logic [DIGIT_W-1:0]   top_digit;
  logic [BIN_W-1:0]     mac_sum;
  logic                 mac_ovf;
  logic                 mac_bad;
  logic                 last_digit;

  assign top_digit  = shift_reg[SW-1 -: DIGIT_W];
  assign last_digit = (count_reg == CW'(NUM_DIGITS - 1));

  bcd_mac10 #(
    .BIN_W(BIN_W)
  ) u_mac (
    .acc       (acc_reg),
    .d         (top_digit),
    .sum       (mac_sum),
    .ovf       (mac_ovf),
    .bad_digit (mac_bad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, step through digits, hold in DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = CONV;
      CONV:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the word, then shift out one digit per cycle into
  // the accumulator while folding in the sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      derr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= bcd;
            count_reg <= '0;
            acc_reg   <= '0;
            derr_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
          end
        end
        CONV: begin
          acc_reg   <= mac_sum;
          ovf_reg   <= ovf_reg | mac_ovf;
          derr_reg  <= derr_reg | mac_bad;
          shift_reg <= shift_reg << DIGIT_W;
          count_reg <= count_reg + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs are pure functions of the state register, so
  // neither ready nor valid has a combinational path from an input.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign binary    = acc_reg;
  assign digit_err = derr_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench: a default (5 digit, 17 bit) converter and a 16-bit
// converter share the same stimulus so overflow can be seen side by side.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] bcd;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_digit_err, a_overflow;
  logic [16:0] a_binary;
  logic        b_in_ready, b_out_valid, b_digit_err, b_overflow;
  logic [15:0] b_binary;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_seq #(.NUM_DIGITS(5), .BIN_W(17)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .bcd       (bcd),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .binary    (a_binary),
    .digit_err (a_digit_err),
    .overflow  (a_overflow)
  );

  bcd_to_binary_seq #(.NUM_DIGITS(5), .BIN_W(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .bcd       (bcd),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .binary    (b_binary),
    .digit_err (b_digit_err),
    .overflow  (b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver: present w, wait for acceptance, then count edges
  // until out_valid. lat = edges after acceptance, or -1 on timeout.
  task automatic convert(input logic [19:0] w, output int lat);
    int waited;
    waited = 0;
    while (!a_in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b1;
    bcd      = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd      = '0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin
        lat = c;
        break;
      end
    end
    $display("xact bcd=%h lat=%0d a_bin=%0d a_err=%0d a_ovf=%0d b_bin=%0d b_ovf=%0d",
             w, lat, a_binary, a_digit_err, a_overflow, b_binary, b_overflow);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; bcd = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_binary !== 17'd0) begin errors++; $display("FAIL reset_binary got %0d want 0", a_binary); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0 || a_digit_err !== 1'b0 || a_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b e=%b o=%b want 0 0 0", a_out_valid, a_digit_err, a_overflow);
    end
  endtask

  task automatic test_basic();
    int lat;
    convert(20'h09999, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (a_binary !== 17'd9999) begin errors++; $display("FAIL basic_binary got %0d want 9999", a_binary); end
    checks++; if (a_digit_err !== 1'b0 || a_overflow !== 1'b0) begin
      errors++; $display("FAIL basic_flags got e=%b o=%b want 0 0", a_digit_err, a_overflow);
    end
    release_out();
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got v=%b r=%b want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_full_range();
    int lat;
    convert(20'h99999, lat);
    checks++; if (a_binary !== 17'h1869F || a_overflow !== 1'b0) begin
      errors++; $display("FAIL full_99999 got %h o=%b want 1869f o=0", a_binary, a_overflow);
    end
    release_out();
    convert(20'h00000, lat);
    checks++; if (a_binary !== 17'd0) begin errors++; $display("FAIL full_zero got %0d want 0", a_binary); end
    release_out();
    convert(20'h01023, lat);
    checks++; if (a_binary !== 17'd1023) begin errors++; $display("FAIL full_1023 got %0d want 1023", a_binary); end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    convert(20'h65535, lat);
    checks++; if (b_binary !== 16'hFFFF || b_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_65535 got %h o=%b want ffff o=0", b_binary, b_overflow);
    end
    release_out();
    convert(20'h65536, lat);
    checks++; if (b_binary !== 16'h0000 || b_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_65536 got %h o=%b want 0000 o=1", b_binary, b_overflow);
    end
    checks++; if (a_binary !== 17'd65536 || a_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_65536_wide got %0d o=%b want 65536 o=0", a_binary, a_overflow);
    end
    release_out();
    convert(20'h99999, lat);
    checks++; if (b_binary !== 16'h869F || b_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_99999 got %h o=%b want 869f o=1", b_binary, b_overflow);
    end
    release_out();
  endtask

  task automatic test_invalid_digit();
    int lat;
    convert(20'h000A5, lat);
    checks++; if (a_binary !== 17'd105 || a_digit_err !== 1'b1 || a_overflow !== 1'b0) begin
      errors++; $display("FAIL bad_digit got %0d e=%b o=%b want 105 e=1 o=0", a_binary, a_digit_err, a_overflow);
    end
    release_out();
    convert(20'h00042, lat);
    checks++; if (a_binary !== 17'd42 || a_digit_err !== 1'b0) begin
      errors++; $display("FAIL bad_digit_clear got %0d e=%b want 42 e=0", a_binary, a_digit_err);
    end
    release_out();
  endtask

  task automatic test_back_pressure();
    int stable_bad;
    int early_valid;
    // Accept 12345, then wiggle in_valid with a different word during CONV.
    in_valid = 1'b1;
    bcd      = 20'h12345;
    @(posedge clk); #1;
    early_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      in_valid = c[0];
      bcd      = 20'h11111;
      @(posedge clk); #1;
      if (a_out_valid || a_in_ready) early_valid++;
    end
    in_valid = 1'b0;
    bcd      = '0;
    checks++; if (early_valid !== 0) begin errors++; $display("FAIL bp_conv_handshake got %0d bad cycles want 0", early_valid); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b1 || a_binary !== 17'd12345) begin
      errors++; $display("FAIL bp_result got v=%b %0d want v=1 12345", a_out_valid, a_binary);
    end
    // Hold the result with out_ready low; in_valid pulses must not disturb it.
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      bcd      = 20'h11111;
      @(posedge clk); #1;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_binary !== 17'd12345 ||
          a_digit_err !== 1'b0 || a_overflow !== 1'b0) stable_bad++;
    end
    in_valid = 1'b0;
    bcd      = '0;
    checks++; if (stable_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", stable_bad); end
    release_out();
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid);
    end
    $display("xact bcd=12345 back-pressure a_bin=%0d", a_binary);
  endtask

  task automatic test_async_reset();
    int lat;
    in_valid = 1'b1;
    bcd      = 20'h12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd      = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (a_binary !== 17'd12) begin errors++; $display("FAIL arst_partial got %0d want 12", a_binary); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_binary !== 17'd0 || a_out_valid !== 1'b0 || a_digit_err !== 1'b0 || a_overflow !== 1'b0) begin
      errors++; $display("FAIL arst_clear got %0d v=%b e=%b o=%b want 0 0 0 0", a_binary, a_out_valid, a_digit_err, a_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL arst_idle got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid);
    end
    convert(20'h00255, lat);
    checks++; if (lat !== 5 || a_binary !== 17'd255) begin
      errors++; $display("FAIL arst_next got lat=%0d %0d want lat=5 255", lat, a_binary);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_overflow();
    test_invalid_digit();
    test_back_pressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got no finish want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
